// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and shifts them out MSB-first on x.
// Optional even-parity trailer bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d        = par_q;
`endif
    load_ready   = 1'b0;
    x            = IDLE_BIT;
    x_valid      = 1'b0;

    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
      end
      S_SHIFT: begin
        x       = shreg_q[WIDTH-1];
        x_valid = !hold;
`ifndef BIT_SERIALIZER_PARITY_EN
        load_ready = (cnt_q == '0) && !hold;
`endif
        if (!hold) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == '0) begin
`ifdef BIT_SERIALIZER_PARITY_EN
            state_d = S_PAR;
`else
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
`endif
          end
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PAR: begin
        x          = par_q;
        x_valid    = !hold;
        load_ready = !hold;
        if (!hold) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // An accepted word overrides the return to IDLE, giving gapless frames.
    if (load_valid && load_ready) begin
      shreg_d = load_data;
      cnt_d   = CW'(WIDTH - 1);
      state_d = S_SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d   = ^load_data;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed plan sequences plus random traffic
// compared against a bit-queue reference model (parity trailer follows BIT_SERIALIZER_PARITY_EN).
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready;
  logic         hold = 1'b0;
  logic         x, x_valid, busy, frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the bits still to be presented for the current frame.
  bit q_bits[$];
  bit fd_e = 1'b0;

  logic [31:0] obs_word;
  int          obs_nbits;

  bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .hold       (hold),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] frame_word(input logic [W-1:0] d);
`ifdef BIT_SERIALIZER_PARITY_EN
    return {23'd0, d, ^d};
`else
    return {24'd0, d};
`endif
  endfunction

  task automatic step(input logic r, input logic lv, input logic [W-1:0] d, input logic h);
    bit busy_e, ready_e, x_e, xv_e;
    @(negedge clk);
    reset = r; load_valid = lv; load_data = d; hold = h;
    #1;
    busy_e  = (q_bits.size() != 0);
    x_e     = busy_e ? q_bits[0] : 1'b0;
    xv_e    = busy_e && !h;
    ready_e = !busy_e || (q_bits.size() == 1 && !h);
    chk("busy", busy, busy_e);
    chk("x", x, x_e);
    chk("x_valid", x_valid, xv_e);
    chk("load_ready", load_ready, ready_e);
    chk("frame_done", frame_done, fd_e);
    if (x_valid === 1'b1) begin
      obs_word = {obs_word[30:0], x};
      obs_nbits++;
    end
    @(posedge clk);
    if (r) begin
      q_bits.delete();
      fd_e = 1'b0;
    end else begin
      fd_e = busy_e && !h && (q_bits.size() == 1);
      if (busy_e && !h) void'(q_bits.pop_front());
      if (lv && ready_e) begin
        for (int i = W - 1; i >= 0; i--) q_bits.push_back(d[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
        q_bits.push_back(^d);
`endif
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    // Plan 1: reset held two cycles, then released idle.
    reset = 1'b1;
    @(posedge clk);
    step(1'b1, 1'b0, '0, 1'b0);
    idle_steps(3);

    // Plan 2: single word.
    obs_word = '0; obs_nbits = 0;
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    idle_steps(FL + 2);
    chk("t2_word", obs_word, frame_word(8'hA5));
    chk("t2_nbits", obs_nbits, FL);

    // Plan 3: back-to-back, second word taken on the last-bit cycle.
    obs_word = '0; obs_nbits = 0;
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < FL; i++) step(1'b0, 1'b1, 8'h3C, 1'b0);
    idle_steps(FL + 2);
    chk("t3_nbits", obs_nbits, 2 * FL);
    chk("t3_word2", obs_word & ((32'd1 << FL) - 1), frame_word(8'h3C));

    // Plan 4: stall for 3 cycles after the 2nd bit.
    obs_word = '0; obs_nbits = 0;
    step(1'b0, 1'b1, 8'hF0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    idle_steps(FL + 2);
    chk("t4_word", obs_word, frame_word(8'hF0));
    chk("t4_nbits", obs_nbits, FL);

    // Plan 5: load attempt while busy, then mid-frame reset.
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    idle_steps(3);

`ifdef BIT_SERIALIZER_PARITY_EN
    // Plan 6: parity trailer values.
    obs_word = '0; obs_nbits = 0;
    step(1'b0, 1'b1, 8'h07, 1'b0);
    idle_steps(FL + 1);
    chk("t6_word07", obs_word, 32'h00F);
    obs_word = '0; obs_nbits = 0;
    step(1'b0, 1'b1, 8'h03, 1'b0);
    idle_steps(FL + 1);
    chk("t6_word03", obs_word, 32'h006);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 1) == 1),
           W'($urandom),
           ($urandom_range(0, 3) == 0));
    end
    idle_steps(FL + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
